prog_ctr_lut: RTL

PROG_CTR_LUT -- requirements
Module: prog_ctr_lut

---
 rtl/prog_ctr_lut_if.sv | 25 ++
 rtl/prog_ctr_lut.sv | 61 ++++++
 2 files changed

// File: rtl/prog_ctr_lut_if.sv
// prog_ctr_lut_if: control, branch request and branch-target-table signals of the program counter
interface prog_ctr_lut_if #(
  parameter int D = 12,
  parameter int A = 5
);
  logic         start;
  logic         halt;
  logic         branch_en;
  logic         cond;
  logic [A-1:0] branch_idx;
  logic [D-1:0] lut_target;
  logic [A-1:0] lut_addr;
  logic [D-1:0] pc;
  logic         stall;
  logic         done;
  logic         err;
  modport master (
    output start, halt, branch_en, cond, branch_idx, lut_target,
    input  lut_addr, pc, stall, done, err
  );
  modport slave (
    input  start, halt, branch_en, cond, branch_idx, lut_target,
    output lut_addr, pc, stall, done, err
  );
endinterface

// File: rtl/prog_ctr_lut.sv
// prog_ctr_lut: program counter FSM with table-indexed conditional branches
module prog_ctr_lut #(
  parameter int D       = 12,
  parameter int A       = 5,
  parameter int MAX_IDX = 16
) (
  input logic            clk,
  input logic            rst_n,
  prog_ctr_lut_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, BRANCH, DONE} state_t;
  state_t state;
  logic   taken;
  logic   idx_ok;
  assign taken  = bus.branch_en && bus.cond;
  assign idx_ok = int'(bus.branch_idx) <= MAX_IDX;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.pc       <= '0;
      bus.lut_addr <= '0;
      bus.stall    <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.stall <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          bus.pc <= '0;
          if (bus.start) state <= RUN;
        end
        RUN: begin
          if (bus.halt) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (taken && idx_ok) begin
            bus.lut_addr <= bus.branch_idx;
            state        <= BRANCH;
            bus.stall    <= 1'b1;
          end else begin
            bus.pc <= bus.pc + 1'b1;
            if (taken) bus.err <= 1'b1;
          end
        end
        // lut_target is looked up from the lut_addr registered on the request edge
        BRANCH: begin
          bus.pc <= bus.lut_target;
          state  <= RUN;
        end
        DONE: begin
          if (bus.start) begin
            bus.pc <= '0;
            state  <= RUN;
          end else bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
